// File: rtl/ddr_rd_arb2_pkg.sv
// Shared types for the two-requester DDR read arbiter.
package ddr_arb_pkg;

    localparam int ARB_AW = 32;
    localparam int ARB_DW = 64;
    localparam int ARB_IW = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [ARB_IW-1:0] id;
        logic [ARB_AW-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } ar_req_t;

endpackage

// File: rtl/ddr_rd_arb2_if.sv
// AXI4 read-channel bundle (AR + R) shared by requesters and the memory side.
interface ddr_rd_arb2_if
    import ddr_arb_pkg::*;
#(
    parameter int AW = ARB_AW,
    parameter int DW = ARB_DW,
    parameter int IW = ARB_IW
);

    logic [IW-1:0] arid;
    logic [AW-1:0] araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;

    logic [IW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/ddr_rd_arb2_rr_pick2.sv
// Two-way grant picker: force0 beats urgent, urgent beats round-robin.
module rr_pick2 (
    input  logic [1:0] valid,
    input  logic       last,
    input  logic       urgent,
    input  logic       force0,
    output logic       grant,
    output logic       grant_valid
);

    // Priority chain; 'last' is the index granted most recently, so a tie goes to the other one.
    always_comb begin
        grant       = 1'b0;
        grant_valid = |valid;
        if (force0 && valid[0]) begin
            grant = 1'b0;
        end else if (urgent && valid[1]) begin
            grant = 1'b1;
        end else if (&valid) begin
            grant = ~last;
        end else begin
            grant = valid[1];
        end
    end

endmodule

// File: rtl/ddr_rd_arb2.sv
// Shares one DDR AXI read port between the CPU (s0) and the VGA fetcher (s1),
// one burst at a time, with a VGA urgent override bounded by CPU starvation.
module ddr_rd_arb2
    import ddr_arb_pkg::*;
#(
    parameter int AW       = ARB_AW,
    parameter int DW       = ARB_DW,
    parameter int IW       = ARB_IW,
    parameter int MAX_WAIT = 64
) (
    input  logic          clk,
    input  logic          rst,
    ddr_rd_arb2_if.slave  s0,
    ddr_rd_arb2_if.slave  s1,
    input  logic          s1_urgent,
    ddr_rd_arb2_if.master m
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    arb_state_t    state;
    logic          grant_idx;
    logic          rr_last;
    logic [CW-1:0] starve_cnt;
    ar_req_t       ar_reg;
    ar_req_t       req_sel;

    logic pick_idx;
    logic pick_valid;
    logic force0;
    logic take;
    logic sel0;
    logic sel1;
    logic last_beat;

    assign force0 = (starve_cnt >= CW'(MAX_WAIT));

    rr_pick2 u_pick (
        .valid       ({s1.arvalid, s0.arvalid}),
        .last        (rr_last),
        .urgent      (s1_urgent),
        .force0      (force0),
        .grant       (pick_idx),
        .grant_valid (pick_valid)
    );

    // Grants are only handed out from IDLE and never while reset is held.
    assign take       = !rst && (state == IDLE) && pick_valid;
    assign s0.arready = take && !pick_idx;
    assign s1.arready = take && pick_idx;

    // Payload of whichever requester the picker chose this cycle.
    always_comb begin
        req_sel = '{id: s0.arid, addr: s0.araddr, len: s0.arlen,
                    size: s0.arsize, burst: s0.arburst};
        if (pick_idx) begin
            req_sel = '{id: s1.arid, addr: s1.araddr, len: s1.arlen,
                        size: s1.arsize, burst: s1.arburst};
        end
    end

    // Downstream AR comes straight from the latched request, so it holds through backpressure.
    assign m.arvalid = (state == ADDR);
    assign m.arid    = ar_reg.id;
    assign m.araddr  = AW'(ar_reg.addr);
    assign m.arlen   = ar_reg.len;
    assign m.arsize  = ar_reg.size;
    assign m.arburst = ar_reg.burst;

    // R beats go only to the granted requester; the other side sees a quiet channel.
    assign sel0      = (state == DATA) && !grant_idx;
    assign sel1      = (state == DATA) && grant_idx;
    assign m.rready  = (sel0 && s0.rready) || (sel1 && s1.rready);
    assign last_beat = m.rvalid && m.rready && m.rlast;

    assign s0.rvalid = sel0 && m.rvalid;
    assign s0.rid    = sel0 ? m.rid   : {IW{1'b0}};
    assign s0.rdata  = sel0 ? m.rdata : {DW{1'b0}};
    assign s0.rresp  = sel0 ? m.rresp : 2'b00;
    assign s0.rlast  = sel0 && m.rlast;

    assign s1.rvalid = sel1 && m.rvalid;
    assign s1.rid    = sel1 ? m.rid   : {IW{1'b0}};
    assign s1.rdata  = sel1 ? m.rdata : {DW{1'b0}};
    assign s1.rresp  = sel1 ? m.rresp : 2'b00;
    assign s1.rlast  = sel1 && m.rlast;

    // Burst FSM: latch the grant, present it downstream, then route beats until rlast.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_idx <= 1'b0;
            rr_last   <= 1'b1;
            ar_reg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_idx <= pick_idx;
                        ar_reg    <= req_sel;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (m.arready) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (last_beat) begin
                        rr_last <= grant_idx;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // CPU wait counter: counts every cycle s0 is pending without a grant, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (s0.arready) begin
            starve_cnt <= '0;
        end else if (s0.arvalid && (starve_cnt < CW'(MAX_WAIT))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // A beat outside DATA means the memory side lost track of the single outstanding burst.
    a_no_stray_beat: assert property (@(posedge clk) disable iff (rst)
        (state != DATA) |-> !m.rvalid);

endmodule

// File: tb/tb_ddr_rd_arb2.sv
// Directed bench for ddr_rd_arb2 with a one-burst-at-a-time memory model.
module tb_ddr_rd_arb2;
    import ddr_arb_pkg::*;

    localparam int MAXW = 4;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic s1_urgent = 1'b0;
    logic mem_ar_en = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic        mem_busy = 1'b0;
    logic [7:0]  mem_len  = 8'd0;
    logic [7:0]  mem_beat = 8'd0;
    logic [31:0] mem_addr = 32'd0;
    logic [5:0]  mem_id   = 6'd0;

    logic [63:0] s0_beats[$];
    logic [63:0] s1_beats[$];
    int          grant_log[$];
    int          grant_cyc[$];

    ddr_rd_arb2_if s0_bus ();
    ddr_rd_arb2_if s1_bus ();
    ddr_rd_arb2_if m_bus ();

    ddr_rd_arb2 #(.MAX_WAIT(MAXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s0        (s0_bus),
        .s1        (s1_bus),
        .s1_urgent (s1_urgent),
        .m         (m_bus)
    );

    always #5 clk = ~clk;

    assign m_bus.arready = mem_ar_en;

    // Memory: accepts one AR, then streams beats whose data encodes {addr, beat index}.
    always @(posedge clk) begin
        if (rst) begin
            mem_busy = 1'b0;
        end else begin
            if (m_bus.rvalid && m_bus.rready) begin
                if (mem_beat == mem_len) mem_busy = 1'b0;
                else mem_beat = mem_beat + 8'd1;
            end
            if (m_bus.arvalid && m_bus.arready) begin
                mem_busy = 1'b1;
                mem_len  = m_bus.arlen;
                mem_beat = 8'd0;
                mem_addr = m_bus.araddr;
                mem_id   = m_bus.arid;
            end
        end
        #1;
        m_bus.rvalid = mem_busy;
        m_bus.rlast  = mem_busy && (mem_beat == mem_len);
        m_bus.rdata  = mem_busy ? {mem_addr, 24'h0, mem_beat} : 64'h0;
        m_bus.rid    = mem_id;
        m_bus.rresp  = 2'b00;
    end

    // Records AR grants and delivered beats on each requester.
    always @(posedge clk) begin
        if (!rst) begin
            if (s0_bus.arvalid && s0_bus.arready) begin
                grant_log.push_back(0);
                grant_cyc.push_back(cyc);
            end
            if (s1_bus.arvalid && s1_bus.arready) begin
                grant_log.push_back(1);
                grant_cyc.push_back(cyc);
            end
            if (s0_bus.rvalid && s0_bus.rready) s0_beats.push_back(s0_bus.rdata);
            if (s1_bus.rvalid && s1_bus.rready) s1_beats.push_back(s1_bus.rdata);
        end
        cyc = cyc + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic set_s0(input logic v, input logic [31:0] a, input logic [7:0] l, input logic [5:0] id);
        s0_bus.arvalid = v;  s0_bus.araddr = a;  s0_bus.arlen = l;
        s0_bus.arid    = id; s0_bus.arsize = 3'd3; s0_bus.arburst = 2'b01;
    endtask

    task automatic set_s1(input logic v, input logic [31:0] a, input logic [7:0] l, input logic [5:0] id);
        s1_bus.arvalid = v;  s1_bus.araddr = a;  s1_bus.arlen = l;
        s1_bus.arid    = id; s1_bus.arsize = 3'd3; s1_bus.arburst = 2'b01;
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        rst = 1'b1;
        set_s0(1'b0, 32'h0, 8'h0, 6'h0);
        set_s1(1'b0, 32'h0, 8'h0, 6'h0);
        s1_urgent = 1'b0;
        mem_ar_en = 1'b1;
        s0_bus.rready = 1'b1;
        s1_bus.rready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        rst = 1'b1;
        set_s0(1'b1, 32'h40, 8'h0, 6'h1);
        set_s1(1'b1, 32'h80, 8'h0, 6'h2);
        s0_bus.rready = 1'b1;
        s1_bus.rready = 1'b1;
        @(negedge clk);
        checks++;
        if (s0_bus.arready !== 1'b0 || s1_bus.arready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_arready: got s0=%b s1=%b expected 0 0", s0_bus.arready, s1_bus.arready);
        end
        checks++;
        if (m_bus.arvalid !== 1'b0 || m_bus.rready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_m_valid: got arvalid=%b rready=%b expected 0 0", m_bus.arvalid, m_bus.rready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        set_s0(1'b0, 32'h0, 8'h0, 6'h0);
        set_s1(1'b0, 32'h0, 8'h0, 6'h0);
        @(negedge clk);
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("[TB] FAIL reset_state: got %0d expected %0d", dut.state, IDLE);
        end
        checks++;
        if (dut.rr_last !== 1'b1 || int'(dut.starve_cnt) != 0) begin
            errors++;
            $display("[TB] FAIL reset_regs: got rr_last=%b starve=%0d expected 1 0", dut.rr_last, dut.starve_cnt);
        end
        checks++;
        if (m_bus.araddr !== 32'h0 || m_bus.arlen !== 8'h0 || s0_bus.rvalid !== 1'b0 || s1_bus.rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_payload: got araddr=%0h arlen=%0h rvalid0=%b rvalid1=%b expected 0",
                     m_bus.araddr, m_bus.arlen, s0_bus.rvalid, s1_bus.rvalid);
        end
    endtask

    task automatic test_single;
        int b0;
        int b1;
        logic [63:0] exp;
        do_reset();
        b0 = s0_beats.size();
        b1 = s1_beats.size();
        set_s0(1'b1, 32'h100, 8'd3, 6'd5);
        @(negedge clk);
        checks++;
        if (s0_bus.arready !== 1'b1 || s1_bus.arready !== 1'b0 || m_bus.arvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_grant: got s0_arready=%b s1_arready=%b m_arvalid=%b expected 1 0 0",
                     s0_bus.arready, s1_bus.arready, m_bus.arvalid);
        end
        @(posedge clk); #1;
        set_s0(1'b0, 32'h0, 8'h0, 6'h0);
        @(negedge clk);
        checks++;
        if (m_bus.arvalid !== 1'b1 || m_bus.araddr !== 32'h100 || m_bus.arlen !== 8'd3 || m_bus.arid !== 6'd5) begin
            errors++;
            $display("[TB] FAIL single_ar: got arvalid=%b addr=%0h len=%0d id=%0d expected 1 100 3 5",
                     m_bus.arvalid, m_bus.araddr, m_bus.arlen, m_bus.arid);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            exp = {32'h100, 24'h0, 8'(k)};
            checks++;
            if (s0_bus.rvalid !== 1'b1 || s0_bus.rdata !== exp || s0_bus.rlast !== (k == 3) || s0_bus.rid !== 6'd5) begin
                errors++;
                $display("[TB] FAIL single_beat%0d: got v=%b d=%0h last=%b id=%0d expected 1 %0h %b 5",
                         k, s0_bus.rvalid, s0_bus.rdata, s0_bus.rlast, s0_bus.rid, exp, (k == 3));
            end
            checks++;
            if (s1_bus.rvalid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL single_s1_quiet%0d: got s1_rvalid=%b expected 0", k, s1_bus.rvalid);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (dut.state !== IDLE || s0_beats.size() - b0 != 4 || s1_beats.size() - b1 != 0) begin
            errors++;
            $display("[TB] FAIL single_done: got state=%0d s0_beats=%0d s1_beats=%0d expected %0d 4 0",
                     dut.state, s0_beats.size() - b0, s1_beats.size() - b1, IDLE);
        end
    endtask

    task automatic test_back_to_back;
        int base;
        int b0;
        int b1;
        bit done;
        do_reset();
        base = grant_log.size();
        b0 = s0_beats.size();
        b1 = s1_beats.size();
        done = 1'b0;
        set_s0(1'b1, 32'h200, 8'd0, 6'd1);
        set_s1(1'b1, 32'h300, 8'd0, 6'd2);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (grant_log.size() - base >= 4) begin
                done = 1'b1;
                break;
            end
        end
        set_s0(1'b0, 32'h0, 8'h0, 6'h0);
        set_s1(1'b0, 32'h0, 8'h0, 6'h0);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL b2b_timeout: got %0d grants expected 4", grant_log.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (grant_log[base + i] != (i % 2)) begin
                    errors++;
                    $display("[TB] FAIL b2b_order%0d: got %0d expected %0d", i, grant_log[base + i], i % 2);
                end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (grant_cyc[base + i] - grant_cyc[base + i - 1] != 3) begin
                    errors++;
                    $display("[TB] FAIL b2b_spacing%0d: got %0d cycles expected 3", i,
                             grant_cyc[base + i] - grant_cyc[base + i - 1]);
                end
            end
        end
        checks++;
        if (s0_beats.size() - b0 != 2 || s1_beats.size() - b1 != 2) begin
            errors++;
            $display("[TB] FAIL b2b_beats: got s0=%0d s1=%0d expected 2 2", s0_beats.size() - b0, s1_beats.size() - b1);
        end else begin
            checks++;
            if (s0_beats[b0] !== {32'h200, 32'h0} || s1_beats[b1 + 1] !== {32'h300, 32'h0}) begin
                errors++;
                $display("[TB] FAIL b2b_data: got s0=%0h s1=%0h expected %0h %0h",
                         s0_beats[b0], s1_beats[b1 + 1], {32'h200, 32'h0}, {32'h300, 32'h0});
            end
        end
    endtask

    task automatic test_urgent;
        int base;
        int seen;
        int n;
        int exp_order[5];
        do_reset();
        exp_order = '{1, 1, 0, 1, 0};
        base = grant_log.size();
        seen = 0;
        s1_urgent = 1'b1;
        set_s0(1'b1, 32'h200, 8'd0, 6'd1);
        set_s1(1'b1, 32'h300, 8'd0, 6'd2);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            n = grant_log.size() - base;
            if (n != seen) begin
                if (n == 2) begin
                    checks++;
                    if (int'(dut.starve_cnt) != MAXW) begin
                        errors++;
                        $display("[TB] FAIL urgent_saturate: got starve=%0d expected %0d", dut.starve_cnt, MAXW);
                    end
                end
                if (n == 3) begin
                    checks++;
                    if (int'(dut.starve_cnt) != 0) begin
                        errors++;
                        $display("[TB] FAIL urgent_clear: got starve=%0d expected 0", dut.starve_cnt);
                    end
                end
                seen = n;
            end
            if (n >= 5) break;
        end
        set_s0(1'b0, 32'h0, 8'h0, 6'h0);
        set_s1(1'b0, 32'h0, 8'h0, 6'h0);
        s1_urgent = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (grant_log.size() - base < 5) begin
            errors++;
            $display("[TB] FAIL urgent_timeout: got %0d grants expected 5", grant_log.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (grant_log[base + i] != exp_order[i]) begin
                    errors++;
                    $display("[TB] FAIL urgent_order%0d: got %0d expected %0d", i, grant_log[base + i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_arready_stall;
        int base;
        int b1;
        bit got;
        do_reset();
        base = grant_log.size();
        b1 = s1_beats.size();
        got = 1'b0;
        mem_ar_en = 1'b0;
        set_s0(1'b1, 32'h4000, 8'd0, 6'd7);
        set_s1(1'b1, 32'h5000, 8'd0, 6'd9);
        @(negedge clk);
        checks++;
        if (s0_bus.arready !== 1'b1 || s1_bus.arready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_grant: got s0=%b s1=%b expected 1 0", s0_bus.arready, s1_bus.arready);
        end
        @(posedge clk); #1;
        set_s0(1'b0, 32'h0, 8'h0, 6'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (m_bus.arvalid !== 1'b1 || m_bus.araddr !== 32'h4000 || m_bus.arid !== 6'd7) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: got arvalid=%b addr=%0h id=%0d expected 1 4000 7",
                         i, m_bus.arvalid, m_bus.araddr, m_bus.arid);
            end
            checks++;
            if (s0_bus.arready !== 1'b0 || s1_bus.arready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_no_arready%0d: got s0=%b s1=%b expected 0 0", i, s0_bus.arready, s1_bus.arready);
            end
            @(posedge clk); #1;
        end
        mem_ar_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (grant_log.size() - base >= 2) set_s1(1'b0, 32'h0, 8'h0, 6'h0);
            if (s1_beats.size() - b1 >= 1) begin
                got = 1'b1;
                break;
            end
        end
        set_s1(1'b0, 32'h0, 8'h0, 6'h0);
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL stall_s1_served: got 0 beats expected 1");
        end else begin
            checks++;
            if (s1_beats[b1] !== {32'h5000, 32'h0}) begin
                errors++;
                $display("[TB] FAIL stall_s1_data: got %0h expected %0h", s1_beats[b1], {32'h5000, 32'h0});
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_rready_toggle;
        int b0;
        bit rr;
        logic [63:0] exp;
        do_reset();
        b0 = s0_beats.size();
        set_s0(1'b1, 32'h800, 8'd7, 6'd3);
        @(posedge clk); #1;
        set_s0(1'b0, 32'h0, 8'h0, 6'h0);
        for (int i = 0; i < 40; i++) begin
            rr = (i % 3 != 1);
            s0_bus.rready = rr;
            @(negedge clk);
            checks++;
            if (s0_bus.rvalid === 1'b1 && m_bus.rready !== rr) begin
                errors++;
                $display("[TB] FAIL toggle_mirror%0d: got m_rready=%b expected %b", i, m_bus.rready, rr);
            end else if (s0_bus.rvalid !== 1'b1 && m_bus.rready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL toggle_idle_rready%0d: got m_rready=%b expected 0", i, m_bus.rready);
            end
            @(posedge clk); #1;
            if (s0_beats.size() - b0 >= 8) break;
        end
        s0_bus.rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s0_beats.size() - b0 != 8) begin
            errors++;
            $display("[TB] FAIL toggle_count: got %0d beats expected 8", s0_beats.size() - b0);
        end else begin
            for (int k = 0; k < 8; k++) begin
                exp = {32'h800, 24'h0, 8'(k)};
                checks++;
                if (s0_beats[b0 + k] !== exp) begin
                    errors++;
                    $display("[TB] FAIL toggle_beat%0d: got %0h expected %0h", k, s0_beats[b0 + k], exp);
                end
            end
        end
    endtask

    task automatic test_reset_midburst;
        int b0;
        bit got;
        do_reset();
        b0 = s0_beats.size();
        got = 1'b0;
        set_s0(1'b1, 32'hA00, 8'd3, 6'd2);
        @(posedge clk); #1;
        set_s0(1'b0, 32'h0, 8'h0, 6'h0);
        for (int i = 0; i < 10; i++) begin
            if (s0_beats.size() - b0 >= 2) break;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.state !== IDLE || m_bus.arvalid !== 1'b0 || m_bus.rready !== 1'b0 || m_bus.araddr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midrst_m: got state=%0d arvalid=%b rready=%b araddr=%0h expected %0d 0 0 0",
                     dut.state, m_bus.arvalid, m_bus.rready, m_bus.araddr, IDLE);
        end
        checks++;
        if (s0_bus.rvalid !== 1'b0 || s1_bus.rvalid !== 1'b0 || s0_bus.arready !== 1'b0 || s1_bus.arready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_s: got rvalid=%b%b arready=%b%b expected 00 00",
                     s0_bus.rvalid, s1_bus.rvalid, s0_bus.arready, s1_bus.arready);
        end
        checks++;
        if (s0_beats.size() - b0 != 2) begin
            errors++;
            $display("[TB] FAIL midrst_beats: got %0d expected 2", s0_beats.size() - b0);
        end
        @(posedge clk); #1;
        set_s0(1'b1, 32'hC00, 8'd1, 6'd4);
        @(posedge clk); #1;
        set_s0(1'b0, 32'h0, 8'h0, 6'h0);
        for (int i = 0; i < 15; i++) begin
            if (s0_beats.size() - b0 >= 4) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL midrst_recover: got %0d beats expected 4", s0_beats.size() - b0);
        end else begin
            checks++;
            if (s0_beats[b0 + 2] !== {32'hC00, 32'h0} || s0_beats[b0 + 3] !== {32'hC00, 32'h1}) begin
                errors++;
                $display("[TB] FAIL midrst_data: got %0h %0h expected %0h %0h",
                         s0_beats[b0 + 2], s0_beats[b0 + 3], {32'hC00, 32'h0}, {32'hC00, 32'h1});
            end
        end
        @(negedge clk);
        checks++;
        if (dut.state !== IDLE) begin
            errors++;
            $display("[TB] FAIL midrst_idle: got %0d expected %0d", dut.state, IDLE);
        end
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        set_s0(1'b0, 32'h0, 8'h0, 6'h0);
        set_s1(1'b0, 32'h0, 8'h0, 6'h0);
        s0_bus.rready = 1'b0;
        s1_bus.rready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_urgent();
        test_arready_stall();
        test_rready_toggle();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_rd_arb2.md
# ddr_rd_arb2

Two-requester AXI4 read-channel arbiter that shares the single DDR read port between the SweRV core's read traffic and the VGA framebuffer fetch engine. It sits in the `clk_core` domain, upstream of the AXI clock-domain crossing that feeds the LiteDRAM controller. The write channels bypass this block. It grants one read burst at a time, using round-robin scheduling. Requester 1 (VGA) has an urgent override, bounded by a starvation limit that protects requester 0 (CPU).

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 64, data width
- `IW`, 6, AXI ID width; IDs pass through unchanged
- `MAX_WAIT`, 64, cycles requester 0 may be held off by urgent requests before it is force-granted

Ports (`sN_` denotes both `s0_` and `s1_`):
- `clk`  in  1  core clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `sN_arid / sN_araddr / sN_arlen / sN_arsize / sN_arburst`  in  IW / AW / 8 / 3 / 2  requester AR payload
- `sN_arvalid`  in  1;  `sN_arready`  out  1
- `sN_rid / sN_rdata / sN_rresp / sN_rlast`  out  IW / DW / 2 / 1  R payload to requester
- `sN_rvalid`  out  1;  `sN_rready`  in  1
- `s1_urgent`  in  1  VGA line-buffer low-water flag
- `m_arid / m_araddr / m_arlen / m_arsize / m_arburst`  out  IW / AW / 8 / 3 / 2  AR toward memory
- `m_arvalid`  out  1;  `m_arready`  in  1
- `m_rid / m_rdata / m_rresp / m_rlast`  in  IW / DW / 2 / 1
- `m_rvalid`  in  1;  `m_rready`  out  1

## Operation
- States:
  - IDLE: no burst granted.
  - ADDR: granted AR is being presented downstream.
  - DATA: the granted burst's R beats are being routed.
- Arbitration, evaluated in IDLE only, in this priority order:
  1. Force-grant requester 0 if `s0_arvalid` is set and `starve_cnt >= MAX_WAIT`.
  2. Otherwise grant requester 1 if `s1_arvalid & s1_urgent`.
  3. Otherwise round-robin: when both are valid, grant the requester not granted last. A single valid requester wins.
- IDLE transitions:
  - On a grant, assert the winner's `sN_arready` combinationally in the same cycle.
  - Latch the AR payload and the grant index into a register.
  - Go to ADDR. The loser's `arready` stays 0.
- ADDR:
  - `m_arvalid=1`, driven from the register.
  - On `m_arready`, go to DATA.
- DATA:
  - `m_r*` is routed to the granted requester and `m_rready` = the granted requester's `sN_rready`.
  - The other requester sees `rvalid=0`.
  - On `m_rvalid & m_rready & m_rlast`, go to IDLE and update the round-robin pointer to the granted index.
- `starve_cnt`:
  - Increments, saturating at `MAX_WAIT`, on every cycle that `s0_arvalid` is high and requester 0 is not granted.
  - Clears on a requester 0 grant.
- Only one burst is outstanding at a time, so R ordering and ID routing are trivial. IDs are never remapped.
- A stray `m_rvalid` in IDLE or ADDR is not accepted (`m_rready=0`). It is an assertion error in simulation.

## Timing
- Reset values:
  - State IDLE.
  - All `*valid` and `*ready` outputs 0.
  - Round-robin pointer = 1, so requester 0 wins the first tie.
  - `starve_cnt` = 0.
  - Payload outputs are 0.
- Latency:
  - An `sN_ar` handshake in cycle T gives `m_arvalid` at T+1.
  - R path is zero-latency combinational, with no added stage.
- Back-to-back: after the last-beat handshake in cycle T, IDLE in T+1 can accept a new AR, so `m_arvalid` rises again at T+2.
- `m_araddr` and the other AR payload outputs must be stable while `m_arvalid=1 & !m_arready`.
- `s1_urgent` is sampled only in IDLE. A change mid-burst has no effect on the burst in flight.
- Simultaneous events:
  - A requester dropping `arvalid` while not granted is allowed. The counter stops, but does not clear.
  - A last beat coinciding with new requests is arbitrated in the next cycle.
- `rst` mid-burst:
  - Returns to IDLE next cycle and drops every valid/ready.
  - The downstream path is reset by the same `rst`, so no orphan beats arrive.

## Structure
- Package `ddr_arb_pkg`:
  - `arb_state_t` enum (IDLE, ADDR, DATA).
  - `ar_req_t` packed struct (id, addr, len, size, burst), parameterised by the package localparams `ARB_AW`, `ARB_DW`, `ARB_IW`.
- Sub-module `rr_pick2`: combinational 2-way picker. Inputs are valid[1:0], last, urgent and force0. Outputs are grant index and grant_valid.
- Top module: FSM, AR register, R mux/demux, starvation counter.

## Test plan
- Only s0 requests `araddr=0x100`, `arlen=3`: `s0_arready` is set in cycle 0, `m_arvalid` in cycle 1, 4 beats reach s0 only, and the FSM returns to IDLE after `rlast`.
- s0 and s1 both valid continuously, no urgent, `arlen=0`: grants alternate 0,1,0,1, with requester 0 first after reset.
- `s1_urgent=1` and both always valid, `MAX_WAIT=4`: s1 is granted repeatedly until `starve_cnt` reaches 4, then s0 is granted once and the counter clears.
- `m_arready` held 0 for 5 cycles: `m_araddr` stays stable, and no second `sN_arready` is issued.
- `s0_rready` toggled during an 8-beat burst: `m_rready` mirrors it, and no beat is lost or duplicated (scoreboard checks the data).
- `rst` asserted on beat 2 of 4: all outputs are 0 the next cycle, state is IDLE, and a new request is served normally afterwards.
